// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store data memory.
//   F3_*        : RV32I load/store funct3 encodings
//   state_e     : controller states of lsu_dmem
//   illegal_f3  : funct3 values that have no meaning for the access direction
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Stores only know SB/SH/SW; loads have no encodings 3, 6 and 7.
    function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 > 3'd2;
        end
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for one load/store access (purely combinational).
//   funct3    in  3   RV32I access size/sign
//   addr_lo   in  2   byte offset inside the word
//   wdata     in  32  right-aligned store data
//   rword     in  32  word read from the array
//   byte_en   out 4   lanes written by a store
//   wdata_sh  out 32  store data replicated onto its lanes
//   rdata_ext out 32  sign/zero-extended load data
//   misalign  out 1   half not on a 2-byte boundary or word not on a 4-byte boundary
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rword[8*addr_lo +: 8];
    assign rd_half = addr_lo[1] ? rword[31:16] : rword[15:0];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        byte_en  = 4'b0000;
        wdata_sh = wdata;
        misalign = 1'b0;
        // Size lives in funct3[1:0] for both loads and stores.
        case (funct3[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << addr_lo;
                wdata_sh = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            2'b10: begin
                byte_en  = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    rdata_ext = {{16{rd_half[15]}}, rd_half};
            F3_W:    rdata_ext = rword;
            F3_BU:   rdata_ext = {24'd0, rd_byte};
            F3_HU:   rdata_ext = {16'd0, rd_half};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_dmem.sv
// Data memory for the RV32I load/store path: byte/half/word accesses,
// valid/ready request, fixed-latency one-cycle response pulse, error flag and
// a post-reset clear walk over the whole array.
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_req_valid / o_req_ready  request handshake (ready only in IDLE)
//   i_req_we, i_req_funct3     store/load and access size/sign
//   i_req_addr, i_req_wdata    byte address, right-aligned store data
//   o_rsp_valid                response pulse, 1+WAIT_CYCLES cycles after accept
//   o_rsp_rdata, o_rsp_err     extended load data (0 on store/error), error flag
//   o_busy                     array clear in progress
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS    = 1024,
    parameter int WAIT_CYCLES    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e       state_q, state_d;
    logic [AW-1:0] clr_idx_q;
    logic [2:0]   wait_cnt_q;

    logic         req_we_q;
    logic [2:0]   req_f3_q;
    logic [31:0]  req_addr_q;

    logic         rsp_err_q;
    logic [31:0]  rsp_rdata_q;

    logic [31:0]  mem [DEPTH_WORDS];

    // The access being worked on: the incoming request while IDLE (accept
    // edge), the latched one afterwards.
    logic          cur_we;
    logic [2:0]    cur_f3;
    logic [31:0]   cur_addr;
    logic [AW-1:0] cur_idx;
    logic          cur_err;
    logic          accept;
    logic          store_commit;
    logic          enter_resp;

    logic [3:0]    byte_en;
    logic [31:0]   wdata_sh;
    logic [31:0]   rdata_ext;
    logic          misalign;

    assign cur_we   = (state_q == IDLE) ? i_req_we     : req_we_q;
    assign cur_f3   = (state_q == IDLE) ? i_req_funct3 : req_f3_q;
    assign cur_addr = (state_q == IDLE) ? i_req_addr   : req_addr_q;
    assign cur_idx  = cur_addr[AW+1:2];

    lsu_align u_align (
        .funct3    (cur_f3),
        .addr_lo   (cur_addr[1:0]),
        .wdata     (i_req_wdata),
        .rword     (mem[cur_idx]),
        .byte_en   (byte_en),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    assign cur_err = (|cur_addr[31:AW+2]) | illegal_f3(cur_we, cur_f3) | misalign;

    assign o_req_ready  = (state_q == IDLE) && !i_reset;
    assign accept       = i_req_valid && o_req_ready;
    assign store_commit = accept && i_req_we && !cur_err;
    assign enter_resp   = (state_d == RESP) && (state_q != RESP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR: if (clr_idx_q == AW'(DEPTH_WORDS - 1)) state_d = IDLE;
            IDLE:  if (accept) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:  if (wait_cnt_q == 3'(WAIT_CYCLES - 1)) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            clr_idx_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            if (state_q == CLEAR) clr_idx_q <= clr_idx_q + 1'b1;
            wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            req_we_q   <= i_req_we;
            req_f3_q   <= i_req_funct3;
            req_addr_q <= i_req_addr;
        end
    end

    // Load data is captured on the edge into RESP so it reflects every
    // store committed before it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (enter_resp) begin
            rsp_err_q   <= cur_err;
            rsp_rdata_q <= (cur_we || cur_err) ? 32'd0 : rdata_ext;
        end
    end

    // NOTE: the array itself has no reset term; it is zeroed by the CLEAR walk
    // one word per cycle, which keeps it mappable onto block RAM.
    always_ff @(posedge i_clk) begin
        if (state_q == CLEAR && !i_reset) begin
            mem[clr_idx_q] <= '0;
        end else if (store_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[cur_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    assign o_rsp_valid = (state_q == RESP) && !i_reset;
    assign o_rsp_err   = o_rsp_valid && rsp_err_q;
    assign o_rsp_rdata = o_rsp_valid ? rsp_rdata_q : 32'd0;
    assign o_busy      = (state_q == CLEAR) && !i_reset;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: instance 0 has no extra latency, instance 1
// has WAIT_CYCLES=3; both use a 16-word array cleared after reset.
module tb_lsu_dmem;
    import lsu_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_f3    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    exp_t sb_q [2][$];
    int n_vec = 0;
    int n_bad = 0;
    int vid   = 0;

    lsu_dmem #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .CLEAR_ON_RESET(1)) dut0 (
        .i_clk(clk), .i_reset(rst[0]),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_we(req_we[0]), .i_req_funct3(req_f3[0]),
        .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
        .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]),
        .o_rsp_err(rsp_err[0]), .o_busy(busy[0])
    );

    lsu_dmem #(.DEPTH_WORDS(16), .WAIT_CYCLES(3), .CLEAR_ON_RESET(1)) dut3 (
        .i_clk(clk), .i_reset(rst[1]),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_we(req_we[1]), .i_req_funct3(req_f3[1]),
        .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
        .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]),
        .o_rsp_err(rsp_err[1]), .o_busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] === 1'b1) begin
                check($sformatf("dut%0d response expected", d), 32'(sb_q[d].size() != 0), 32'd1);
                if (sb_q[d].size() != 0) begin
                    e = sb_q[d].pop_front();
                    check($sformatf("dut%0d v%0d rdata", d, e.id), rsp_rdata[d], e.rdata);
                    check($sformatf("dut%0d v%0d err", d, e.id), {31'd0, rsp_err[d]}, {31'd0, e.err});
                end
            end
        end
    end

    // Present one request, hold it until accepted, then drop valid.
    task automatic issue(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input bit push);
        int n = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_f3[d]    = f3;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        while (req_ready[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[d] !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL dut%0d accept timeout: ready=%b, expected 1", d, req_ready[d]);
        end else begin
            if (push) begin
                sb_q[d].push_back('{rdata: exp_rd, err: exp_err, id: 16'(vid)});
                vid++;
            end
            @(posedge clk);
            #1;
        end
        req_valid[d] = 1'b0;
    endtask

    task automatic st(input int d, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_err);
        issue(d, 1'b1, f3, addr, wdata, 32'd0, exp_err, 1'b1);
    endtask

    task automatic ld(input int d, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp_rd, input logic exp_err);
        issue(d, 1'b0, f3, addr, 32'd0, exp_rd, exp_err, 1'b1);
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (sb_q[d].size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d pending responses", d), sb_q[d].size(), 32'd0);
    endtask

    // Called at the negedge where reset was released: counts busy cycles and
    // any response pulses seen while clearing.
    task automatic measure_clear(input int d, output int busy_cnt, output int pulses);
        busy_cnt = 0;
        pulses   = 0;
        #1;
        while (busy[d] === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            if (rsp_valid[d] === 1'b1) pulses++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int bc, pc;
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_f3[d]    = 3'd0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
        end
        repeat (3) @(negedge clk);

        // Reset state and clear duration
        check("reset busy",   {31'd0, busy[0]},      32'd0);
        check("reset ready",  {31'd0, req_ready[0]}, 32'd0);
        check("reset rsp",    {31'd0, rsp_valid[0]}, 32'd0);
        check("reset rdata",  rsp_rdata[0],          32'd0);
        rst[0] = 1'b0;
        measure_clear(0, bc, pc);
        check("dut0 clear cycles", bc, 32'd16);
        check("dut0 ready after clear", {31'd0, req_ready[0]}, 32'd1);
        @(negedge clk);
        rst[1] = 1'b0;
        measure_clear(1, bc, pc);
        check("dut1 clear cycles", bc, 32'd16);

        ld(0, F3_W, 32'h3C, 32'h0000_0000, 1'b0);

        // Byte/word merge and extension
        st(0, F3_W, 32'h10, 32'hDEAD_BEEF, 1'b0);
        st(0, F3_B, 32'h11, 32'h0000_00A5, 1'b0);
        ld(0, F3_W,  32'h10, 32'hDEAD_A5EF, 1'b0);
        ld(0, F3_B,  32'h11, 32'hFFFF_FFA5, 1'b0);
        ld(0, F3_BU, 32'h11, 32'h0000_00A5, 1'b0);

        // Upper half-word
        st(0, F3_H, 32'h22, 32'h0000_8001, 1'b0);
        ld(0, F3_H,  32'h22, 32'hFFFF_8001, 1'b0);
        ld(0, F3_HU, 32'h22, 32'h0000_8001, 1'b0);
        ld(0, F3_W,  32'h20, 32'h8001_0000, 1'b0);

        // Errors: no write, zero data
        st(0, F3_W, 32'h13, 32'h1111_1111, 1'b1);
        ld(0, F3_W, 32'h10, 32'hDEAD_A5EF, 1'b0);
        ld(0, F3_H, 32'h21, 32'h0000_0000, 1'b1);
        ld(0, F3_W, 32'h40, 32'h0000_0000, 1'b1);
        ld(0, 3'd3, 32'h10, 32'h0000_0000, 1'b1);
        st(0, 3'd3, 32'h10, 32'h2222_2222, 1'b1);
        ld(0, F3_W, 32'h10, 32'hDEAD_A5EF, 1'b0);

        // Last byte in range, positive byte sign extension
        st(0, F3_B, 32'h3F, 32'h0000_0080, 1'b0);
        ld(0, F3_B, 32'h3F, 32'hFFFF_FF80, 1'b0);
        ld(0, F3_W, 32'h3C, 32'h8000_0000, 1'b0);
        st(0, F3_B, 32'h30, 32'h0000_007F, 1'b0);
        ld(0, F3_B, 32'h30, 32'h0000_007F, 1'b0);
        drain(0);

        // Latency with WAIT_CYCLES=3
        st(1, F3_W, 32'h10, 32'hCAFE_F00D, 1'b0);
        ld(1, F3_HU, 32'h07, 32'h0000_0000, 1'b1);
        drain(1);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_f3[1]    = F3_W;
        req_addr[1]  = 32'h10;
        check("t5 ready at t", {31'd0, req_ready[1]}, 32'd1);
        sb_q[1].push_back('{rdata: 32'hCAFE_F00D, err: 1'b0, id: 16'(vid)});
        vid++;
        @(posedge clk);
        #1;
        req_f3[1]   = F3_BU;
        req_addr[1] = 32'h13;
        sb_q[1].push_back('{rdata: 32'h0000_00CA, err: 1'b0, id: 16'(vid)});
        vid++;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("t5 ready t+%0d", k), {31'd0, req_ready[1]}, 32'(k == 5));
            check($sformatf("t5 rsp_valid t+%0d", k), {31'd0, rsp_valid[1]}, 32'(k == 4));
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        drain(1);

        // Reset during WAIT drops the request and restarts the clear
        st(1, F3_W, 32'h08, 32'h1234_5678, 1'b0);
        ld(1, F3_W, 32'h08, 32'h1234_5678, 1'b0);
        drain(1);
        issue(1, 1'b0, F3_W, 32'h08, 32'd0, 32'd0, 1'b0, 1'b0);
        rst[1] = 1'b1;
        @(negedge clk);
        check("t6 rsp in reset", {31'd0, rsp_valid[1]}, 32'd0);
        check("t6 busy in reset", {31'd0, busy[1]}, 32'd0);
        @(negedge clk);
        check("t6 rsp in reset 2", {31'd0, rsp_valid[1]}, 32'd0);
        rst[1] = 1'b0;
        measure_clear(1, bc, pc);
        check("t6 clear cycles", bc, 32'd16);
        check("t6 rsp during clear", pc, 32'd0);
        ld(1, F3_W, 32'h08, 32'h0000_0000, 1'b0);
        drain(1);
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
